// File: rtl/bcd7seg_scan.sv
// bcd7seg_scan: multiplexed 4-digit common-anode 7-segment driver.
// Digits are double-buffered: cargar writes a pending register, and the
// display register only picks it up at a frame boundary, so a frame is never
// torn between two values.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
module bcd7seg_scan #(
  parameter int DIV_CNT = 50000,
  parameter int GUARD   = 500,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] miles,
  input  logic [3:0] centenas,
  input  logic [3:0] decenas,
  input  logic [3:0] unidades,
  input  logic       cargar,
  input  logic [3:0] punto,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       listo
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

  // Digit word layout: {miles, centenas, decenas, unidades, punto}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [19:0]      pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic [19:0]      disp_q, disp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             listo_q, listo_d;

  logic             slot_end;
  logic             frame_end;
  logic [19:0]      in_word;
  logic [3:0]       digit;
  logic             blank;
  logic             in_guard;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;  // dash flags a non-BCD digit
    endcase
    return s;
  endfunction

  // Slot counter and scan index; idx wraps 0 -> 3 naturally on decrement
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd0);
    cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d     = slot_end ? idx_q - 2'd1 : idx_q;
    listo_d   = frame_end;
  end

  // Pending/display double buffer; a load on the boundary edge bypasses pending
  always_comb begin
    in_word    = {miles, centenas, decenas, unidades, punto};
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    disp_d     = disp_q;
    if (cargar) pend_val_d = in_word;
    if (frame_end) begin
      if (cargar)      disp_d = in_word;
      else if (pend_q) disp_d = pend_val_q;
      pend_d = 1'b0;
    end else if (cargar) begin
      pend_d = 1'b1;
    end
  end

  // Digit selection and optional leading-zero blanking from the display register
  always_comb begin
    case (idx_q)
      2'd3:    digit = disp_q[19:16];
      2'd2:    digit = disp_q[15:12];
      2'd1:    digit = disp_q[11:8];
      default: digit = disp_q[7:4];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    blank = (disp_q[19:16] == 4'd0);
      2'd2:    blank = (disp_q[19:12] == 8'd0);
      2'd1:    blank = (disp_q[19:8] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  // Next registered display outputs: all dark during guard, one anode otherwise
  always_comb begin
    in_guard = (cnt_q < GUARD_CNT);
    an_d     = 4'b1111;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    if (!in_guard) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank ? 7'h7F : decode(digit);
      dp_d  = ~disp_q[idx_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= 2'd3;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      disp_q     <= '0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      listo_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      listo_q    <= listo_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign listo = listo_q;

endmodule
